psum_deskew_accumulator: RTL and testbench

- Sits directly below the bottom row of the RPE systolic array and consumes the SIZE column Partial_Sum_out buses.
- Removes the diagonal column skew (column c lags column 0 by c cycles) and sign-extends each column result.
- Accumulates results across K-tiles in a per-row buffer.
- Pushes completed output rows into an output FIFO with a valid/ready handshake toward the writeback stage.

---
 rtl/psum_deskew_accumulator.sv | 174 +++++++++++++++++
 tb/tb_psum_deskew_accumulator.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_deskew_accumulator.sv
// Deskews the SIZE column partial sums leaving the bottom of the systolic
// array, sign-extends them and accumulates them across K-tiles in a per-row
// buffer. Rows that complete their accumulation go into a first-word-fall-through
// output FIFO with a valid/ready handshake. Requires SIZE >= 2 and DEPTH >= 2.
module psum_deskew_accumulator #(
    parameter int SIZE              = 8,
    parameter int PARTIAL_SUM_WIDTH = 8 + 4 + 4 + $clog2(SIZE),
    parameter int ACC_WIDTH         = PARTIAL_SUM_WIDTH + 4,
    parameter int DEPTH             = SIZE,
    parameter int OUT_DEPTH         = 2 * SIZE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SIZE*PARTIAL_SUM_WIDTH-1:0] psum_in,
    input  logic                           in_valid,
    input  logic                           in_first,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic [SIZE*ACC_WIDTH-1:0]      out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           ovf_err
);

    localparam int PSW    = PARTIAL_SUM_WIDTH;
    localparam int LINE   = SIZE - 1;
    localparam int ROW_W  = SIZE * ACC_WIDTH;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OPTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam int INF_W  = $clog2(SIZE);

    // Control line: valid, first and last travel with column 0 timing.
    logic [LINE-1:0] vl_valid;
    logic [LINE-1:0] vl_first;
    logic [LINE-1:0] vl_last;

    // Shift the qualifiers; first/last are stored already gated by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vl_valid <= '0;
            vl_first <= '0;
            vl_last  <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every stage samples its pre-edge neighbour.
            vl_valid[0] <= in_valid;
            vl_first[0] <= in_valid & in_first;
            vl_last[0]  <= in_valid & in_last;
            for (int i = 1; i < LINE; i++) begin
                vl_valid[i] <= vl_valid[i-1];
                vl_first[i] <= vl_first[i-1];
                vl_last[i]  <= vl_last[i-1];
            end
        end
    end

    logic a_valid, a_first, a_last;
    assign a_valid = vl_valid[LINE-1];
    assign a_first = vl_first[LINE-1];
    assign a_last  = vl_last[LINE-1];

    // Column c already lags column 0 by c cycles, so it needs SIZE-1-c more.
    logic [SIZE-1:0][PSW-1:0] lane_aligned;

    for (genvar c = 0; c < SIZE; c++) begin : g_col
        if (c == SIZE - 1) begin : g_pass
            assign lane_aligned[c] = psum_in[c*PSW +: PSW];
        end else begin : g_dly
            localparam int STAGES = SIZE - 1 - c;
            logic [PSW-1:0] pipe [STAGES];

            // Data delay stages; validity is carried by the control line.
            // NOTE: data pipes and storage arrays are not reset; only control state is.
            always_ff @(posedge clk) begin
                pipe[0] <= psum_in[c*PSW +: PSW];
                for (int i = 1; i < STAGES; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end

            assign lane_aligned[c] = pipe[STAGES-1];
        end
    end

    // Rows ending a tile that are still travelling through the deskew line.
    logic [INF_W-1:0] inflight_last;

    // Count last-qualified rows in flight.
    always_comb begin
        // NOTE: combinational outputs get a default first so no path can infer a latch.
        inflight_last = '0;
        for (int i = 0; i < LINE; i++) begin
            inflight_last = inflight_last + INF_W'(vl_last[i]);
        end
    end

    logic [SIZE-1:0][ACC_WIDTH-1:0] acc_buf [DEPTH];
    logic [PTR_W-1:0]               row_ptr;
    logic [SIZE-1:0][ACC_WIDTH-1:0] ext_row;
    logic [SIZE-1:0][ACC_WIDTH-1:0] sum_row;

    // Sign-extend each aligned lane and add it to the buffered row unless starting fresh.
    always_comb begin
        ext_row = '0;
        sum_row = '0;
        for (int c = 0; c < SIZE; c++) begin
            ext_row[c] = {{(ACC_WIDTH-PSW){lane_aligned[c][PSW-1]}}, lane_aligned[c]};
            sum_row[c] = a_first ? ext_row[c] : acc_buf[row_ptr][c] + ext_row[c];
        end
    end

    // Store the running sum of the row at the align point.
    always_ff @(posedge clk) begin
        if (a_valid) begin
            acc_buf[row_ptr] <= sum_row;
        end
    end

    // Walk the buffer rows in arrival order, wrapping after DEPTH rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_ptr <= '0;
        end else if (a_valid) begin
            row_ptr <= (row_ptr == PTR_W'(DEPTH - 1)) ? '0 : row_ptr + 1'b1;
        end
    end

    // Output FIFO.
    logic [ROW_W-1:0]  fifo_mem [OUT_DEPTH];
    logic [OPTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, push_req, do_push, do_pop;

    function automatic logic [OPTR_W-1:0] fifo_next(input logic [OPTR_W-1:0] p);
        return (p == OPTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(OUT_DEPTH));
    assign out_valid = (count != '0);
    assign do_pop    = out_valid & out_ready;
    assign push_req  = a_valid & a_last;
    // A pop frees the head slot this edge, so a push into a full FIFO still fits.
    assign do_push   = push_req & (~full | do_pop);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

    // Write completed rows into the FIFO storage.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= sum_row;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= fifo_next(wr_ptr);
            if (do_pop)  rd_ptr <= fifo_next(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
            if (push_req && !do_push)    ovf_err <= 1'b1;
        end
    end

    // Leave room for a whole tile of rows beyond those already committed.
    logic [CNT_W:0] committed;
    assign committed = {1'b0, count} + (CNT_W+1)'(inflight_last);
    assign in_ready  = (committed <= (CNT_W+1)'(OUT_DEPTH - SIZE));

endmodule

// File: tb/tb_psum_deskew_accumulator.sv
// Directed bench for psum_deskew_accumulator: deskew, sign extension,
// two-tile accumulation, backpressure, overflow and reset mid-tile.
module tb_psum_deskew_accumulator;

    localparam int SIZE  = 8;
    localparam int PSW   = 19;
    localparam int ACC   = 23;
    localparam int ROW_W = SIZE * ACC;
    localparam int NROWS = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [SIZE*PSW-1:0]   psum_in;
    logic                  in_valid, in_first, in_last, in_ready;
    logic [ROW_W-1:0]      out_data;
    logic                  out_valid, out_ready, ovf_err;

    psum_deskew_accumulator #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .psum_in   (psum_in),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int first_in_cyc = -1;
    int first_out_cyc = -1;

    logic [PSW-1:0]   rv [NROWS][SIZE];
    bit               rf [NROWS];
    bit               rl [NROWS];
    int               hist [SIZE];
    logic [ROW_W-1:0] cap [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted output rows and the first cycle out_valid is seen.
    always @(negedge clk) begin
        if (rst_n && out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (rst_n && out_valid && out_ready) cap.push_back(out_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_hist();
        for (int c = 0; c < SIZE; c++) hist[c] = -1;
    endtask

    // One clock: issue row idx (or idle with -1) and drive skewed columns.
    task automatic tick(input int idx);
        @(posedge clk);
        #1;
        for (int c = SIZE - 1; c > 0; c--) hist[c] = hist[c-1];
        hist[0] = idx;
        if (idx >= 0 && first_in_cyc < 0) first_in_cyc = cyc;
        in_valid = (idx >= 0);
        in_first = (idx >= 0) ? rf[idx] : 1'b0;
        in_last  = (idx >= 0) ? rl[idx] : 1'b0;
        for (int c = 0; c < SIZE; c++) begin
            psum_in[c*PSW +: PSW] = (hist[c] >= 0) ? rv[hist[c]][c] : '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(-1);
    endtask

    task automatic set_row(input int idx, input int val, input bit f, input bit l);
        for (int c = 0; c < SIZE; c++) rv[idx][c] = PSW'(val);
        rf[idx] = f;
        rl[idx] = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        psum_in = '0; out_ready = 1'b0;
        clear_hist();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid got=%b exp=0", out_valid); miscompares++;
        end
        vectors++;
        if (out_data !== '0) begin
            $display("FAIL reset_out_data got=%h exp=0", out_data); miscompares++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got=%b exp=1", in_ready); miscompares++;
        end
        vectors++;
        if (ovf_err !== 1'b0) begin
            $display("FAIL reset_ovf_err got=%b exp=0", ovf_err); miscompares++;
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single_tile();
        logic [ROW_W-1:0] exp_row;
        out_ready = 1'b1;
        cap.delete();
        first_in_cyc = -1;
        first_out_cyc = -1;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) rv[r][c] = PSW'(r*16 + c);
            rf[r] = 1'b1; rl[r] = 1'b1;
        end
        for (int r = 0; r < SIZE; r++) tick(r);
        idle(20);
        vectors++;
        if (cap.size() != SIZE) begin
            $display("FAIL single_count got=%0d exp=%0d", cap.size(), SIZE); miscompares++;
        end
        for (int i = 0; i < SIZE; i++) begin
            if (i < cap.size()) begin
                for (int c = 0; c < SIZE; c++) exp_row[c*ACC +: ACC] = ACC'(i*16 + c);
                vectors++;
                if (cap[i] !== exp_row) begin
                    $display("FAIL single_row%0d got=%h exp=%h", i, cap[i], exp_row); miscompares++;
                end
            end
        end
        vectors++;
        if (first_out_cyc - first_in_cyc != SIZE) begin
            $display("FAIL single_latency got=%0d exp=%0d", first_out_cyc - first_in_cyc, SIZE);
            miscompares++;
        end
    endtask

    task automatic test_negative();
        logic [ROW_W-1:0] got;
        out_ready = 1'b1;
        cap.delete();
        set_row(0, 0, 1'b1, 1'b1);
        rv[0][3] = 19'h7FFFF;
        rv[0][0] = 19'h40000;
        tick(0);
        idle(12);
        vectors++;
        if (cap.size() != 1) begin
            $display("FAIL neg_count got=%0d exp=1", cap.size()); miscompares++;
        end else begin
            got = cap[0];
            vectors++;
            if (got[3*ACC +: ACC] !== 23'h7FFFFF) begin
                $display("FAIL neg_lane3 got=%h exp=7fffff", got[3*ACC +: ACC]); miscompares++;
            end
            vectors++;
            if (got[0 +: ACC] !== 23'h7C0000) begin
                $display("FAIL neg_lane0 got=%h exp=7c0000", got[0 +: ACC]); miscompares++;
            end
            vectors++;
            if (got[ACC +: ACC] !== 23'h0) begin
                $display("FAIL neg_lane1 got=%h exp=0", got[ACC +: ACC]); miscompares++;
            end
        end
    endtask

    task automatic test_two_tile();
        logic [ROW_W-1:0] exp_row;
        out_ready = 1'b1;
        cap.delete();
        for (int r = 0; r < SIZE; r++) set_row(r, 5, 1'b1, 1'b0);
        for (int r = SIZE; r < 2*SIZE; r++) set_row(r, -2, 1'b0, 1'b1);
        for (int r = 0; r < SIZE; r++) tick(r);
        idle(12);
        vectors++;
        if (out_valid !== 1'b0 || cap.size() != 0) begin
            $display("FAIL tile_a_no_output got_valid=%b got_rows=%0d exp_valid=0 exp_rows=0",
                     out_valid, cap.size());
            miscompares++;
        end
        for (int r = SIZE; r < 2*SIZE; r++) tick(r);
        idle(12);
        vectors++;
        if (cap.size() != SIZE) begin
            $display("FAIL two_tile_count got=%0d exp=%0d", cap.size(), SIZE); miscompares++;
        end
        for (int c = 0; c < SIZE; c++) exp_row[c*ACC +: ACC] = 23'd3;
        for (int i = 0; i < SIZE; i++) begin
            if (i < cap.size()) begin
                vectors++;
                if (cap[i] !== exp_row) begin
                    $display("FAIL two_tile_row%0d got=%h exp=%h", i, cap[i], exp_row); miscompares++;
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [ROW_W-1:0] exp_row;
        out_ready = 1'b0;
        cap.delete();
        for (int i = 0; i < 3*SIZE; i++) begin
            for (int c = 0; c < SIZE; c++) rv[i][c] = PSW'(i*8 + c);
            rf[i] = 1'b1; rl[i] = 1'b1;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_ready_batch1 got=%b exp=1", in_ready); miscompares++;
        end
        for (int i = 0; i < SIZE; i++) tick(i);
        tick(SIZE);
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_ready_at_8 got=%b exp=1", in_ready); miscompares++;
        end
        tick(SIZE + 1);
        vectors++;
        if (in_ready !== 1'b0) begin
            $display("FAIL bp_ready_at_9 got=%b exp=0", in_ready); miscompares++;
        end
        for (int i = SIZE + 2; i < 2*SIZE; i++) tick(i);
        idle(12);
        vectors++;
        if (in_ready !== 1'b0 || ovf_err !== 1'b0 || out_valid !== 1'b1 || cap.size() != 0) begin
            $display("FAIL bp_held got ready=%b ovf=%b valid=%b rows=%0d exp ready=0 ovf=0 valid=1 rows=0",
                     in_ready, ovf_err, out_valid, cap.size());
            miscompares++;
        end
        out_ready = 1'b1;
        idle(24);
        vectors++;
        if (cap.size() != 2*SIZE || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL bp_drain got rows=%0d ready=%b valid=%b exp rows=16 ready=1 valid=0",
                     cap.size(), in_ready, out_valid);
            miscompares++;
        end
        for (int i = 2*SIZE; i < 3*SIZE; i++) tick(i);
        idle(12);
        vectors++;
        if (cap.size() != 3*SIZE || ovf_err !== 1'b0) begin
            $display("FAIL bp_total got rows=%0d ovf=%b exp rows=24 ovf=0", cap.size(), ovf_err);
            miscompares++;
        end
        for (int i = 0; i < 3*SIZE; i++) begin
            if (i < cap.size()) begin
                for (int c = 0; c < SIZE; c++) exp_row[c*ACC +: ACC] = ACC'(i*8 + c);
                vectors++;
                if (cap[i] !== exp_row) begin
                    $display("FAIL bp_row%0d got=%h exp=%h", i, cap[i], exp_row); miscompares++;
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [ROW_W-1:0] exp_row;
        out_ready = 1'b0;
        cap.delete();
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < SIZE; c++) rv[i][c] = PSW'(512 + i*8 + c);
            rf[i] = 1'b1; rl[i] = 1'b1;
        end
        for (int i = 0; i < 20; i++) tick(i);
        idle(12);
        vectors++;
        if (ovf_err !== 1'b1) begin
            $display("FAIL ovf_flag got=%b exp=1", ovf_err); miscompares++;
        end
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            $display("FAIL ovf_full got ready=%b valid=%b exp ready=0 valid=1", in_ready, out_valid);
            miscompares++;
        end
        out_ready = 1'b1;
        idle(24);
        vectors++;
        if (cap.size() != 16) begin
            $display("FAIL ovf_retained got=%0d exp=16", cap.size()); miscompares++;
        end
        for (int i = 0; i < 16; i++) begin
            if (i < cap.size()) begin
                for (int c = 0; c < SIZE; c++) exp_row[c*ACC +: ACC] = ACC'(512 + i*8 + c);
                vectors++;
                if (cap[i] !== exp_row) begin
                    $display("FAIL ovf_row%0d got=%h exp=%h", i, cap[i], exp_row); miscompares++;
                end
            end
        end
        vectors++;
        if (ovf_err !== 1'b1) begin
            $display("FAIL ovf_sticky got=%b exp=1", ovf_err); miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        logic [ROW_W-1:0] exp_row;
        out_ready = 1'b0;
        cap.delete();
        set_row(0, 7, 1'b1, 1'b1);
        tick(0);
        idle(10);
        vectors++;
        if (out_valid !== 1'b1) begin
            $display("FAIL rmid_preload got=%b exp=1", out_valid); miscompares++;
        end
        for (int r = 1; r <= 4; r++) set_row(r, 9, 1'b1, 1'b0);
        for (int r = 1; r <= 4; r++) tick(r);
        rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; psum_in = '0;
        clear_hist();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || ovf_err !== 1'b0) begin
            $display("FAIL rmid_async got valid=%b ovf=%b exp valid=0 ovf=0", out_valid, ovf_err);
            miscompares++;
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || ovf_err !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL rmid_held got valid=%b ovf=%b ready=%b exp valid=0 ovf=0 ready=1",
                     out_valid, ovf_err, in_ready);
            miscompares++;
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < SIZE; r++) set_row(8 + r, r + 1, 1'b1, 1'b0);
        for (int r = 0; r < SIZE; r++) set_row(16 + r, 100, 1'b0, 1'b1);
        for (int i = 8; i < 24; i++) tick(i);
        idle(16);
        vectors++;
        if (cap.size() != SIZE) begin
            $display("FAIL rmid_count got=%0d exp=%0d", cap.size(), SIZE); miscompares++;
        end
        for (int i = 0; i < SIZE; i++) begin
            if (i < cap.size()) begin
                for (int c = 0; c < SIZE; c++) exp_row[c*ACC +: ACC] = ACC'(i + 1 + 100);
                vectors++;
                if (cap[i] !== exp_row) begin
                    $display("FAIL rmid_row%0d got=%h exp=%h", i, cap[i], exp_row); miscompares++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_negative();
        test_two_tile();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
